// File: rtl/core_pkg.sv
// Shared decoder field encodings and execution-controller state type.
// Imported by the execute-stage control logic.
package core_pkg;

  typedef enum logic [1:0] {
    CTRL_EXEC = 2'd0,
    CTRL_MEM  = 2'd1,
    CTRL_AMO  = 2'd2
  } ctrl_path_e;

  typedef enum logic [1:0] {
    ENG_ALU = 2'd0,
    ENG_MUL = 2'd1,
    ENG_DIV = 2'd2,
    ENG_RSV = 2'd3
  } exec_engine_e;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_EXEC = 2'd1,
    WB_MEM  = 2'd2,
    WB_PC   = 2'd3
  } wb_src_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EXEC       = 3'd1,
    S_ENG_WAIT   = 3'd2,
    S_MEM_REQ    = 3'd3,
    S_MEM_RSP    = 3'd4,
    S_FAULT_WAIT = 3'd5
  } ctrl_state_e;

  localparam int unsigned WDOG_W = 16;

  function automatic logic is_multicycle(
    input exec_engine_e eng
  );
    return (eng == ENG_MUL) || (eng == ENG_DIV);
  endfunction

endpackage

// File: rtl/core_mem_watchdog.sv
// Memory-response watchdog: counts waiting cycles, flags the limit.
// Saturates at the limit so it never wraps back to zero.
module core_mem_watchdog
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [WDOG_W-1:0] LIMIT =
    WDOG_W'(MEM_TIMEOUT);

  logic [WDOG_W-1:0] cnt_q;

  assign timeout = (cnt_q >= LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/core_exec_ctrl.sv
// Execute-stage sequencer: ALU/engine/memory/AMO control strobes,
// trap and fault reporting, and the architectural instret counter.
module core_exec_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  ctrl_path_e   ctrl_path,
  input  exec_engine_e exec_engine,
  input  wb_src_e      wb_src,
  input  logic         ecall,
  output logic         exec_phase,
  output logic         eng_start,
  input  logic         eng_done,
  output logic         mem_req,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic         mem_err,
  output logic         rf_we,
  output logic         pc_we,
  output logic         retire,
  output logic         trap,
  output logic         fault,
  output logic [63:0]  instret
);

  ctrl_state_e state_q, state_d;
  logic        phase_q, phase_d;
  logic [63:0] instret_q;

  logic rdy_s, start_s, req_s;
  logic rf_s, pc_s, ret_s;
  logic trap_s, fault_s;
  logic wd_clr, wd_en, wd_to;

  core_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .timeout(wd_to)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (ret_s) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rdy_s   = 1'b0;
    start_s = 1'b0;
    req_s   = 1'b0;
    rf_s    = 1'b0;
    pc_s    = 1'b0;
    ret_s   = 1'b0;
    trap_s  = 1'b0;
    fault_s = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rdy_s = 1'b1;
        if (instr_valid) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ecall) begin
          trap_s  = 1'b1;
          state_d = S_IDLE;
        end else if (ctrl_path == CTRL_EXEC &&
                     !is_multicycle(exec_engine)) begin
          rf_s    = (wb_src != WB_NONE);
          pc_s    = 1'b1;
          ret_s   = 1'b1;
          state_d = S_IDLE;
        end else if (ctrl_path == CTRL_EXEC) begin
          start_s = 1'b1;
          state_d = S_ENG_WAIT;
        end else begin
          state_d = S_MEM_REQ;
        end
      end
      S_ENG_WAIT: begin
        if (eng_done) begin
          rf_s    = 1'b1;
          pc_s    = 1'b1;
          ret_s   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_MEM_REQ: begin
        req_s = 1'b1;
        if (mem_gnt) begin
          wd_clr  = 1'b1;
          state_d = S_MEM_RSP;
        end
      end
      S_MEM_RSP: begin
        wd_en = 1'b1;
        if (mem_rvalid) begin
          if (mem_err) begin
            fault_s = 1'b1;
            state_d = S_IDLE;
          end else if (ctrl_path == CTRL_AMO && !phase_q) begin
            rf_s    = 1'b1;
            phase_d = 1'b1;
            state_d = S_MEM_REQ;
          end else begin
            rf_s    = (wb_src != WB_NONE);
            pc_s    = 1'b1;
            ret_s   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (wd_to) begin
          fault_s = 1'b1;
          wd_clr  = 1'b1;
          state_d = S_FAULT_WAIT;
        end
      end
      S_FAULT_WAIT: begin
        // bounded so a response that never comes cannot wedge the core
        wd_en = 1'b1;
        if (mem_rvalid || wd_to) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_IDLE) begin
      phase_d = 1'b0;
    end
  end

  assign instr_ready = rdy_s   & ~rst;
  assign eng_start   = start_s & ~rst;
  assign mem_req     = req_s   & ~rst;
  assign rf_we       = rf_s    & ~rst;
  assign pc_we       = pc_s    & ~rst;
  assign retire      = ret_s   & ~rst;
  assign trap        = trap_s  & ~rst;
  assign fault       = fault_s & ~rst;
  assign exec_phase  = phase_q & ~rst;
  assign instret     = rst ? 64'd0 : instret_q;

endmodule

// File: tb/tb_core_exec_ctrl.sv
// Directed bench for core_exec_ctrl with per-cycle expected strobes
// and an instret reference count.
module tb_core_exec_ctrl;
  import core_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic         instr_ready;
  ctrl_path_e   ctrl_path;
  exec_engine_e exec_engine;
  wb_src_e      wb_src;
  logic         ecall;
  logic         exec_phase;
  logic         eng_start;
  logic         eng_done;
  logic         mem_req;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic         mem_err;
  logic         rf_we;
  logic         pc_we;
  logic         retire;
  logic         trap;
  logic         fault;
  logic [63:0]  instret;

  always #5 clk = ~clk;

  core_exec_ctrl #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .ctrl_path  (ctrl_path),
    .exec_engine(exec_engine),
    .wb_src     (wb_src),
    .ecall      (ecall),
    .exec_phase (exec_phase),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_err    (mem_err),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .retire     (retire),
    .trap       (trap),
    .fault      (fault),
    .instret    (instret)
  );

  localparam logic [5:0] I_RST = 6'b100000;
  localparam logic [5:0] I_V   = 6'b010000;
  localparam logic [5:0] I_G   = 6'b001000;
  localparam logic [5:0] I_RV  = 6'b000100;
  localparam logic [5:0] I_ER  = 6'b000010;
  localparam logic [5:0] I_DN  = 6'b000001;

  localparam logic [8:0] E_RDY = 9'h100;
  localparam logic [8:0] E_PH  = 9'h080;
  localparam logic [8:0] E_ST  = 9'h040;
  localparam logic [8:0] E_REQ = 9'h020;
  localparam logic [8:0] E_RF  = 9'h010;
  localparam logic [8:0] E_PC  = 9'h008;
  localparam logic [8:0] E_RT  = 9'h004;
  localparam logic [8:0] E_TR  = 9'h002;
  localparam logic [8:0] E_FL  = 9'h001;
  localparam logic [8:0] E_WB  = E_RF | E_PC | E_RT;

  int          n_chk = 0;
  int          n_fail = 0;
  logic        run = 1'b0;
  logic [8:0]  exp_o = '0;
  logic [63:0] m_instret = '0;
  string       nm [9] = '{"fault", "trap", "retire",
                          "pc_we", "rf_we", "mem_req",
                          "eng_start", "exec_phase",
                          "instr_ready"};

  always @(negedge clk) begin
    logic [8:0]  act;
    logic [63:0] ei;
    if (run) begin
      act = {instr_ready, exec_phase, eng_start,
             mem_req, rf_we, pc_we, retire, trap, fault};
      for (int i = 0; i < 9; i++) begin
        n_chk++;
        if (act[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL %s: got %b want %b at %0t",
                   nm[i], act[i], exp_o[i], $time);
        end
      end
      ei = rst ? 64'd0 : m_instret;
      n_chk++;
      if (instret !== ei) begin
        n_fail++;
        $display("FAIL instret: got %0d want %0d at %0t",
                 instret, ei, $time);
      end
      if (rst) m_instret = '0;
      else if (exp_o[2]) m_instret = m_instret + 64'd1;
    end
  end

  task automatic cyc(input logic [5:0] in_v,
                     input logic [8:0] e);
    {rst, instr_valid, mem_gnt,
     mem_rvalid, mem_err, eng_done} = in_v;
    exp_o = e;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input ctrl_path_e p,
                       input exec_engine_e g,
                       input wb_src_e w,
                       input logic e);
    ctrl_path   = p;
    exec_engine = g;
    wb_src      = w;
    ecall       = e;
  endtask

  task automatic lit(input string n,
                     input logic [63:0] want);
    n_chk++;
    if (instret !== want) begin
      n_fail++;
      $display("FAIL %s: instret got %0d want %0d",
               n, instret, want);
    end
  endtask

  initial begin
    instr(CTRL_EXEC, ENG_ALU, WB_EXEC, 1'b0);
    cyc(I_RST, '0);
    run = 1'b1;
    cyc(I_RST, '0);
    cyc('0, E_RDY);

    // ADDI
    cyc(I_V, E_RDY);
    cyc('0, E_WB);
    lit("addi_instret", 64'd1);
    cyc('0, E_RDY);

    // back-to-back ALU, valid held through EXEC
    cyc(I_V, E_RDY);
    cyc(I_V, E_WB);
    cyc(I_V, E_RDY);
    cyc('0, E_WB);
    cyc('0, E_RDY);

    // RSV engine, no write-back
    instr(CTRL_EXEC, ENG_RSV, WB_NONE, 1'b0);
    cyc(I_V, E_RDY);
    cyc('0, E_PC | E_RT);
    cyc('0, E_RDY);

    // MUL, done 5 cycles after start
    instr(CTRL_EXEC, ENG_MUL, WB_EXEC, 1'b0);
    cyc(I_V, E_RDY);
    cyc(I_DN, E_ST);
    for (int i = 0; i < 4; i++) cyc('0, '0);
    cyc(I_DN, E_WB);
    lit("mul_instret", 64'd5);
    cyc('0, E_RDY);

    // AMOADD, grant after 3 low cycles, rvalid 2 after grant
    instr(CTRL_AMO, ENG_ALU, WB_MEM, 1'b0);
    cyc(I_V, E_RDY);
    cyc('0, '0);
    for (int i = 0; i < 3; i++) cyc('0, E_REQ);
    cyc(I_G | I_RV, E_REQ);
    cyc('0, '0);
    cyc(I_RV, E_RF);
    for (int i = 0; i < 3; i++) cyc('0, E_REQ | E_PH);
    cyc(I_G, E_REQ | E_PH);
    cyc('0, E_PH);
    cyc(I_RV, E_PH | E_WB);
    cyc('0, E_RDY);

    // load with error response
    instr(CTRL_MEM, ENG_ALU, WB_MEM, 1'b0);
    cyc(I_V, E_RDY);
    cyc('0, '0);
    cyc(I_G, E_REQ);
    cyc(I_ER, '0);
    cyc(I_RV | I_ER, E_FL);
    lit("err_instret", 64'd6);
    cyc('0, E_RDY);

    // good load, minimum latency
    cyc(I_V, E_RDY);
    cyc('0, '0);
    cyc(I_G, E_REQ);
    cyc(I_RV, E_WB);
    cyc('0, E_RDY);

    // timeout with a late response absorbed
    cyc(I_V, E_RDY);
    cyc('0, '0);
    cyc(I_G, E_REQ);
    for (int i = 0; i < 4; i++) cyc('0, '0);
    cyc('0, E_FL);
    cyc('0, '0);
    cyc(I_RV, '0);
    cyc(I_RV, E_RDY);
    instr(CTRL_EXEC, ENG_ALU, WB_EXEC, 1'b0);
    cyc(I_V, E_RDY);
    cyc('0, E_WB);
    cyc('0, E_RDY);

    // ECALL
    instr(CTRL_EXEC, ENG_ALU, WB_EXEC, 1'b1);
    cyc(I_V, E_RDY);
    cyc('0, E_TR);
    cyc('0, E_RDY);
    lit("pre_rst_instret", 64'd8);

    // reset while waiting for a response
    instr(CTRL_MEM, ENG_ALU, WB_MEM, 1'b0);
    cyc(I_V, E_RDY);
    cyc('0, '0);
    cyc(I_G, E_REQ);
    cyc('0, '0);
    cyc(I_RST, '0);
    cyc(I_RV, E_RDY);
    lit("post_rst_instret", 64'd0);

    // reset while requesting drops mem_req at once
    cyc(I_V, E_RDY);
    cyc('0, '0);
    cyc(I_RST, '0);
    cyc('0, E_RDY);
    cyc('0, E_RDY);

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
